// File: rtl/vgachargen_fill_arb.sv
// Shares the vgachargen char_map/col_map ports between a host port and a
// fill engine that paints every word of both maps with one char/colour code.
module vgachargen_fill_arb #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 600
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              fill_start_i,
  input  logic [7:0]        fill_char_i,
  input  logic [7:0]        fill_col_i,
  output logic              fill_busy_o,
  output logic              fill_done_o,
  input  logic              host_req_i,
  input  logic              host_sel_i,
  input  logic              host_we_i,
  input  logic [3:0]        host_be_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [31:0]       host_wdata_i,
  output logic              host_gnt_o,
  output logic              host_rvalid_o,
  output logic [31:0]       host_rdata_o,
  output logic [ADDR_W-1:0] char_map_addr_o,
  output logic              char_map_we_o,
  output logic [3:0]        char_map_be_o,
  output logic [31:0]       char_map_wdata_o,
  input  logic [31:0]       char_map_rdata_i,
  output logic [ADDR_W-1:0] col_map_addr_o,
  output logic              col_map_we_o,
  output logic [3:0]        col_map_be_o,
  output logic [31:0]       col_map_wdata_o,
  input  logic [31:0]       col_map_rdata_i,
  output logic              dbg_state_o
);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] cnt;
  logic              done_q;
  logic              rvalid_q;
  logic              rsel_q;
  logic              last_write;

  assign last_write = (state == FILL) && (cnt == LAST_ADDR);

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state    <= IDLE;
      cnt      <= '0;
      done_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rsel_q   <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= last_write;
      // Counter idles at 0 so a new fill always starts at word 0.
      if (state == FILL && !last_write) cnt <= cnt + ADDR_W'(1);
      else                              cnt <= '0;
      rvalid_q <= host_gnt_o & ~host_we_i;
      if (host_gnt_o) rsel_q <= host_sel_i;
    end
  end

  // Host handshake: a request is accepted in any cycle where host_gnt_o=1;
  // until then the host holds req/sel/we/be/addr/wdata stable. A granted read
  // returns data with host_rvalid_o one cycle later; writes have no response.
  always_comb begin
    state_next       = state;
    host_gnt_o       = 1'b0;
    char_map_addr_o  = host_addr_i;
    char_map_be_o    = host_be_i;
    char_map_wdata_o = host_wdata_i;
    char_map_we_o    = 1'b0;
    col_map_addr_o   = host_addr_i;
    col_map_be_o     = host_be_i;
    col_map_wdata_o  = host_wdata_i;
    col_map_we_o     = 1'b0;
    case (state)
      IDLE: begin
        host_gnt_o    = host_req_i;
        char_map_we_o = host_req_i & host_we_i & ~host_sel_i;
        col_map_we_o  = host_req_i & host_we_i & host_sel_i;
        if (fill_start_i) state_next = FILL;
      end
      FILL: begin
        char_map_addr_o  = cnt;
        char_map_be_o    = 4'hF;
        char_map_wdata_o = {4{fill_char_i}};
        char_map_we_o    = 1'b1;
        col_map_addr_o   = cnt;
        col_map_be_o     = 4'hF;
        col_map_wdata_o  = {4{fill_col_i}};
        col_map_we_o     = 1'b1;
        if (cnt == LAST_ADDR) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign fill_busy_o   = (state == FILL);
  assign fill_done_o   = done_q;
  assign host_rvalid_o = rvalid_q;
  assign host_rdata_o  = rvalid_q ? (rsel_q ? col_map_rdata_i : char_map_rdata_i) : 32'h0;
  assign dbg_state_o   = logic'(state);

endmodule
